// File: rtl/issuer_pkg.sv
// Shared types and constants for the command issuer: command/instruction
// formats, scoreboard entry layout, sequencer states and small bit helpers.
package issuer_pkg;

    localparam int PROC_COUNT = 4;
    localparam int ID_W       = 8;
    localparam int OP_W       = 16;
    localparam int PROC_W     = $clog2(PROC_COUNT);

    localparam logic [PROC_W-1:0] PROC_IDX_ONE  = PROC_W'(1);
    localparam logic [PROC_W-1:0] PROC_IDX_LAST = PROC_W'(PROC_COUNT - 1);

    // Command as held in the queue; id 0 means "no dependency" in dep.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] dep;
        logic [OP_W-1:0] op_a;
        logic [OP_W-1:0] op_b;
        logic [OP_W-1:0] info;
    } cmd_t;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_LD1  = 2'd1,
        KIND_LD2  = 2'd2,
        KIND_INFO = 2'd3
    } instr_kind_e;

    typedef struct packed {
        instr_kind_e     kind;
        logic [OP_W-1:0] data;
    } instr_t;

    // Scoreboard entry: in-flight cmd id and the processor running it.
    typedef struct packed {
        logic [ID_W-1:0]   key;
        logic [PROC_W-1:0] val;
    } entry_t;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        CMD_GET       = 4'd1,
        CMD_CHECK     = 4'd2,
        SIMD_SELECT   = 4'd3,
        SIMD_LD1      = 4'd4,
        SIMD_LD2      = 4'd5,
        SIMD_INFO     = 4'd6,
        WAIT_ACK      = 4'd7,
        CMD_WRITEBACK = 4'd8,
        PROC_FINISH   = 4'd9,
        SEND_ACK      = 4'd10
    } state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [PROC_W-1:0] lowest_set(input logic [PROC_COUNT-1:0] vec);
        logic [PROC_W-1:0] pos;
        pos = {PROC_W{1'b0}};
        for (int i = PROC_COUNT - 1; i >= 0; i--) begin
            pos = vec[i] ? PROC_W'(i) : pos;
        end
        return pos;
    endfunction

    // Index of the lowest clear bit; 0 when every bit is set.
    function automatic logic [PROC_W-1:0] lowest_clear(input logic [PROC_COUNT-1:0] vec);
        return lowest_set(~vec);
    endfunction

    function automatic logic [PROC_COUNT-1:0] onehot(input logic [PROC_W-1:0] idx);
        logic [PROC_COUNT-1:0] v;
        v      = {PROC_COUNT{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cmd_scoreboard.sv
// Scoreboard of in-flight commands: one entry per processor at most.
// Insert goes to the lowest invalid slot (dropped when full), lookup is
// combinational on a dependency id, clear invalidates one slot per call
// when it belongs to the given processor.
module cmd_scoreboard
    import issuer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              insert_en,
    input  entry_t            insert_entry,
    input  logic [ID_W-1:0]   lookup_key,
    output logic              lookup_hit,
    input  logic              clear_en,
    input  logic [PROC_W-1:0] clear_idx,
    input  logic [PROC_W-1:0] clear_val
);

    entry_t                map_r [PROC_COUNT];
    logic [PROC_COUNT-1:0] valid_r;

    logic                  free_found_s;
    logic [PROC_W-1:0]     free_idx_s;
    logic                  hit_any_s;
    logic                  clear_match_s;

    // Free-slot search and dependency match over all slots
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {PROC_W{1'b0}};
        hit_any_s    = 1'b0;
        for (int i = PROC_COUNT - 1; i >= 0; i--) begin
            free_found_s = free_found_s | ~valid_r[i];
            free_idx_s   = valid_r[i] ? free_idx_s : PROC_W'(i);
            hit_any_s    = hit_any_s | (valid_r[i] & (map_r[i].key == lookup_key));
        end
        lookup_hit    = hit_any_s & (lookup_key != {ID_W{1'b0}});
        clear_match_s = clear_en & valid_r[clear_idx] & (map_r[clear_idx].val == clear_val);
    end

    // Slot storage: insert into first free slot, invalidate on matching clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {PROC_COUNT{1'b0}};
            for (int i = 0; i < PROC_COUNT; i++) begin
                map_r[i] <= '0;
            end
        end else begin
            if (insert_en && free_found_s) begin
                valid_r[free_idx_s] <= 1'b1;
                map_r[free_idx_s]   <= insert_entry;
            end
            if (clear_match_s) begin
                valid_r[clear_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmd_issuer.sv
// Dispatch stage between the command queue and the SIMD processors.
// Pops a command, checks its dependency against the in-flight scoreboard,
// then either issues it (LD1, LD2, INFO handshakes) to the lowest free
// processor or writes it back to the queue. Finished processors are
// retired first: their scoreboard entries are cleared and the finish is acked.
// Optional build macro ISSUER_PERF_CNT_EN adds o_issue_cnt / o_wb_cnt.
module cmd_issuer
    import issuer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_ack_queue,
    input  logic [PROC_COUNT-1:0] i_busy_proc,
    input  logic [PROC_COUNT-1:0] i_finish_proc,
    input  logic [PROC_COUNT-1:0] i_ack_proc,
    input  cmd_t                  i_cmd,
    output logic [PROC_COUNT-1:0] o_en_proc,
    output logic [PROC_COUNT-1:0] o_ack_proc,
    output instr_t                o_instr,
    output logic                  o_rd_queue,
    output cmd_t                  o_cmd
`ifdef ISSUER_PERF_CNT_EN
    ,
    output logic [15:0]           o_issue_cnt,
    output logic [15:0]           o_wb_cnt
`endif
);

    state_e            state_r;
    state_e            ret_state_r;
    cmd_t              cmd_r;
    logic              hit_r;
    logic [1:0]        chk_cnt_r;
    logic [PROC_W-1:0] sel_r;
    logic [PROC_W-1:0] fin_pos_r;
    logic [PROC_W-1:0] scan_idx_r;
    logic              wb_pend_r;

    logic [PROC_W-1:0] sel_s;
    logic              lookup_hit_s;
    logic              insert_en_s;
    entry_t            insert_entry_s;
    logic              clear_en_s;
    logic              issue_evt_s;
    logic              wb_evt_s;

    // Scoreboard control and handshake completion events
    always_comb begin
        sel_s          = lowest_clear(i_busy_proc);
        insert_en_s    = (state_r == SIMD_SELECT);
        insert_entry_s = '{key: cmd_r.id, val: sel_s};
        clear_en_s     = (state_r == PROC_FINISH);
        wb_evt_s       = (state_r == WAIT_ACK) & wb_pend_r & i_ack_queue;
        issue_evt_s    = (state_r == WAIT_ACK) & ~wb_pend_r & i_ack_proc[sel_r]
                         & (ret_state_r == IDLE);
    end

    cmd_scoreboard u_enq_cmds (
        .clk          (i_clk),
        .rst_n        (i_rstn),
        .insert_en    (insert_en_s),
        .insert_entry (insert_entry_s),
        .lookup_key   (cmd_r.dep),
        .lookup_hit   (lookup_hit_s),
        .clear_en     (clear_en_s),
        .clear_idx    (scan_idx_r),
        .clear_val    (fin_pos_r)
    );

    // Main sequencer: state, registered handshake outputs and captured command
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r     <= IDLE;
            ret_state_r <= IDLE;
            cmd_r       <= '0;
            hit_r       <= 1'b0;
            chk_cnt_r   <= 2'd0;
            sel_r       <= {PROC_W{1'b0}};
            fin_pos_r   <= {PROC_W{1'b0}};
            scan_idx_r  <= {PROC_W{1'b0}};
            wb_pend_r   <= 1'b0;
            o_en_proc   <= {PROC_COUNT{1'b0}};
            o_ack_proc  <= {PROC_COUNT{1'b0}};
            o_instr     <= '0;
            o_rd_queue  <= 1'b0;
            o_cmd       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Retiring a finished processor takes priority over issuing.
                    if (|i_finish_proc) begin
                        state_r    <= PROC_FINISH;
                        fin_pos_r  <= lowest_set(i_finish_proc);
                        scan_idx_r <= {PROC_W{1'b0}};
                    end else if (~&i_busy_proc) begin
                        state_r    <= CMD_GET;
                        o_rd_queue <= 1'b1;
                    end
                end
                CMD_GET: begin
                    o_rd_queue <= 1'b0;
                    chk_cnt_r  <= 2'd0;
                    state_r    <= CMD_CHECK;
                end
                CMD_CHECK: begin
                    case (chk_cnt_r)
                        2'd0: begin
                            cmd_r     <= i_cmd;
                            chk_cnt_r <= 2'd1;
                        end
                        2'd1: begin
                            hit_r     <= lookup_hit_s;
                            chk_cnt_r <= 2'd2;
                        end
                        default: begin
                            chk_cnt_r <= 2'd0;
                            if (hit_r) begin
                                state_r <= CMD_WRITEBACK;
                                o_cmd   <= cmd_r;
                            end else begin
                                state_r <= SIMD_SELECT;
                            end
                        end
                    endcase
                end
                SIMD_SELECT: begin
                    sel_r     <= sel_s;
                    o_en_proc <= onehot(sel_s);
                    o_instr   <= '{kind: KIND_LD1, data: cmd_r.op_a};
                    state_r   <= SIMD_LD1;
                end
                SIMD_LD1: begin
                    ret_state_r <= SIMD_LD2;
                    state_r     <= WAIT_ACK;
                end
                SIMD_LD2: begin
                    ret_state_r <= SIMD_INFO;
                    state_r     <= WAIT_ACK;
                end
                SIMD_INFO: begin
                    ret_state_r <= IDLE;
                    state_r     <= WAIT_ACK;
                end
                CMD_WRITEBACK: begin
                    wb_pend_r   <= 1'b1;
                    ret_state_r <= IDLE;
                    state_r     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (wb_pend_r) begin
                        if (i_ack_queue) begin
                            wb_pend_r <= 1'b0;
                            o_cmd     <= '0;
                            state_r   <= IDLE;
                        end
                    end else if (i_ack_proc[sel_r]) begin
                        state_r <= ret_state_r;
                        case (ret_state_r)
                            SIMD_LD2:  o_instr <= '{kind: KIND_LD2, data: cmd_r.op_b};
                            SIMD_INFO: o_instr <= '{kind: KIND_INFO, data: cmd_r.info};
                            default: begin
                                o_instr   <= '0;
                                o_en_proc <= {PROC_COUNT{1'b0}};
                            end
                        endcase
                    end
                end
                PROC_FINISH: begin
                    // One scoreboard slot examined per cycle.
                    scan_idx_r <= scan_idx_r + PROC_IDX_ONE;
                    if (scan_idx_r == PROC_IDX_LAST) begin
                        o_ack_proc <= onehot(fin_pos_r);
                        state_r    <= SEND_ACK;
                    end
                end
                SEND_ACK: begin
                    if (!i_finish_proc[fin_pos_r]) begin
                        o_ack_proc <= {PROC_COUNT{1'b0}};
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    o_en_proc  <= {PROC_COUNT{1'b0}};
                    o_ack_proc <= {PROC_COUNT{1'b0}};
                    o_instr    <= '0;
                    o_rd_queue <= 1'b0;
                    o_cmd      <= '0;
                end
            endcase
        end
    end

`ifdef ISSUER_PERF_CNT_EN
    // Wrapping counters of completed issues and accepted writebacks
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_issue_cnt <= 16'd0;
            o_wb_cnt    <= 16'd0;
        end else begin
            if (issue_evt_s) begin
                o_issue_cnt <= o_issue_cnt + 16'd1;
            end
            if (wb_evt_s) begin
                o_wb_cnt <= o_wb_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_evt_s;
    assign unused_evt_s = issue_evt_s ^ wb_evt_s;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed, table-driven bench for cmd_issuer. Each vector holds the inputs
// applied before one rising edge and the state/outputs expected after it.
module tb_cmd_issuer;
    import issuer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  ack_queue;
    logic [PROC_COUNT-1:0] busy_proc, finish_proc, ack_proc_in;
    cmd_t                  cmd_in;
    logic [PROC_COUNT-1:0] en_proc, ack_proc_out;
    instr_t                instr;
    logic                  rd_queue;
    cmd_t                  cmd_out;
`ifdef ISSUER_PERF_CNT_EN
    logic [15:0]           issue_cnt, wb_cnt;
`endif

    always #5 clk = ~clk;

    cmd_issuer dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_ack_queue   (ack_queue),
        .i_busy_proc   (busy_proc),
        .i_finish_proc (finish_proc),
        .i_ack_proc    (ack_proc_in),
        .i_cmd         (cmd_in),
        .o_en_proc     (en_proc),
        .o_ack_proc    (ack_proc_out),
        .o_instr       (instr),
        .o_rd_queue    (rd_queue),
        .o_cmd         (cmd_out)
`ifdef ISSUER_PERF_CNT_EN
        ,
        .o_issue_cnt   (issue_cnt),
        .o_wb_cnt      (wb_cnt)
`endif
    );

    typedef struct {
        logic [3:0] busy;
        logic [3:0] fin;
        logic [3:0] ackp;
        logic       ackq;
        cmd_t       cmd;
        state_e     st;
        logic       rd;
        logic [3:0] en;
        logic [3:0] acko;
        instr_t     instr;
        cmd_t       ocmd;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    cmd_t cz, c2, c3, c4, c5, c6;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] busy, input logic [3:0] fin,
                       input logic [3:0] ackp, input logic ackq, input cmd_t cmd,
                       input state_e st, input logic rd, input logic [3:0] en,
                       input logic [3:0] acko, input instr_kind_e kind,
                       input logic [15:0] data, input cmd_t ocmd);
        vec_t v;
        v.busy = busy; v.fin = fin; v.ackp = ackp; v.ackq = ackq; v.cmd = cmd;
        v.st = st; v.rd = rd; v.en = en; v.acko = acko;
        v.instr.kind = kind; v.instr.data = data; v.ocmd = ocmd;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check_outputs(input int idx, input vec_t v);
        check("state",    idx, 64'(dut.state_r), 64'(v.st));
        check("rd_queue", idx, 64'(rd_queue),    64'(v.rd));
        check("en_proc",  idx, 64'(en_proc),     64'(v.en));
        check("ack_proc", idx, 64'(ack_proc_out), 64'(v.acko));
        check("instr",    idx, 64'(instr),       64'(v.instr));
        check("o_cmd",    idx, 64'(cmd_out),     64'(v.ocmd));
    endtask

    task automatic run(input int from);
        for (int i = from; i < vecs.size(); i++) begin
            busy_proc   = vecs[i].busy;
            finish_proc = vecs[i].fin;
            ack_proc_in = vecs[i].ackp;
            ack_queue   = vecs[i].ackq;
            cmd_in      = vecs[i].cmd;
            @(posedge clk);
            @(negedge clk);
            check_outputs(i, vecs[i]);
        end
    endtask

    initial begin
        vec_t zv;
        int   start;
        cz = '0;
        c2 = '{id: 8'd2, dep: 8'd1, op_a: 16'hA002, op_b: 16'hB002, info: 16'hC002};
        c3 = '{id: 8'd3, dep: 8'd2, op_a: 16'hA003, op_b: 16'hB003, info: 16'hC003};
        c4 = '{id: 8'd4, dep: 8'd3, op_a: 16'hA004, op_b: 16'hB004, info: 16'hC004};
        c5 = '{id: 8'd5, dep: 8'd0, op_a: 16'hA005, op_b: 16'hB005, info: 16'hC005};
        c6 = '{id: 8'd6, dep: 8'd5, op_a: 16'hA006, op_b: 16'hB006, info: 16'hC006};

        zv.busy = 4'hF; zv.fin = 4'h0; zv.ackp = 4'h0; zv.ackq = 1'b0; zv.cmd = cz;
        zv.st = IDLE; zv.rd = 1'b0; zv.en = 4'h0; zv.acko = 4'h0; zv.instr = '0; zv.ocmd = cz;

        // Reset with all processors busy
        rstn = 1'b0; busy_proc = 4'hF; finish_proc = 4'h0; ack_proc_in = 4'h0;
        ack_queue = 1'b0; cmd_in = cz;
        repeat (3) @(negedge clk);
        check_outputs(-1, zv);
        rstn = 1'b1;

        // Issue {2,1} to proc 2 through LD1/LD2/INFO
        add(2, 4'hF, 4'h0, 4'h0, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hB, 4'h0, 4'h0, 1'b0, c2, CMD_GET,     1'b1, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(3, 4'hB, 4'h0, 4'h0, 1'b0, c2, CMD_CHECK,   1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hB, 4'h0, 4'h0, 1'b0, c2, SIMD_SELECT, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hB, 4'h0, 4'h0, 1'b0, c2, SIMD_LD1,    1'b0, 4'h4, 4'h0, KIND_LD1,  16'hA002, cz);
        add(3, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h4, 4'h0, KIND_LD1,  16'hA002, cz);
        add(1, 4'hF, 4'h0, 4'hF, 1'b0, cz, SIMD_LD2,    1'b0, 4'h4, 4'h0, KIND_LD2,  16'hB002, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h4, 4'h0, KIND_LD2,  16'hB002, cz);
        add(1, 4'hF, 4'h0, 4'hF, 1'b0, cz, SIMD_INFO,   1'b0, 4'h4, 4'h0, KIND_INFO, 16'hC002, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h4, 4'h0, KIND_INFO, 16'hC002, cz);
        add(1, 4'hF, 4'h0, 4'hF, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        // {3,2} depends on in-flight id 2: written back
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c3, CMD_GET,       1'b1, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(3, 4'hE, 4'h0, 4'h0, 1'b0, c3, CMD_CHECK,     1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c3, CMD_WRITEBACK, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, c3);
        add(2, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,      1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, c3);
        add(1, 4'hF, 4'h0, 4'h0, 1'b1, cz, IDLE,          1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        // Proc 2 finishes: entry for id 2 scanned out, then ack until finish drops
        add(4, 4'hF, 4'h4, 4'h0, 1'b0, cz, PROC_FINISH, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(2, 4'hF, 4'h4, 4'h0, 1'b0, cz, SEND_ACK,    1'b0, 4'h0, 4'h4, KIND_NONE, 16'h0, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        // Requeued {3,2} now issues to proc 0
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c3, CMD_GET,     1'b1, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(3, 4'hE, 4'h0, 4'h0, 1'b0, c3, CMD_CHECK,   1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c3, SIMD_SELECT, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c3, SIMD_LD1,    1'b0, 4'h1, 4'h0, KIND_LD1,  16'hA003, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h1, 4'h0, KIND_LD1,  16'hA003, cz);
        add(1, 4'hF, 4'h0, 4'hF, 1'b0, cz, SIMD_LD2,    1'b0, 4'h1, 4'h0, KIND_LD2,  16'hB003, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h1, 4'h0, KIND_LD2,  16'hB003, cz);
        add(1, 4'hF, 4'h0, 4'hF, 1'b0, cz, SIMD_INFO,   1'b0, 4'h1, 4'h0, KIND_INFO, 16'hC003, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h1, 4'h0, KIND_INFO, 16'hC003, cz);
        add(1, 4'hF, 4'h0, 4'hF, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        // Finish and a free proc together: finish first, lowest finish bit (1)
        add(4, 4'hE, 4'h6, 4'h0, 1'b0, cz, PROC_FINISH, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hE, 4'h6, 4'h0, 1'b0, cz, SEND_ACK,    1'b0, 4'h0, 4'h2, KIND_NONE, 16'h0, cz);
        add(1, 4'hE, 4'h4, 4'h0, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        // Proc 1 retiring left id 3 (proc 0) intact: {4,3} is written back
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c4, CMD_GET,       1'b1, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(3, 4'hE, 4'h0, 4'h0, 1'b0, c4, CMD_CHECK,     1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hE, 4'h0, 4'h0, 1'b0, c4, CMD_WRITEBACK, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, c4);
        add(2, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,      1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, c4);
        add(1, 4'hF, 4'h0, 4'h0, 1'b1, cz, IDLE,          1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(4, 4'hF, 4'h1, 4'h0, 1'b0, cz, PROC_FINISH,   1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'hF, 4'h1, 4'h0, 1'b0, cz, SEND_ACK,      1'b0, 4'h0, 4'h1, KIND_NONE, 16'h0, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, IDLE,          1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        run(0);
`ifdef ISSUER_PERF_CNT_EN
        check("issue_cnt", -2, 64'(issue_cnt), 64'd2);
        check("wb_cnt",    -2, 64'(wb_cnt),    64'd2);
`endif

        // Issue {5,0} to proc 3 and reset while waiting for the LD1 ack
        start = vecs.size();
        add(1, 4'h7, 4'h0, 4'h0, 1'b0, c5, CMD_GET,     1'b1, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(3, 4'h7, 4'h0, 4'h0, 1'b0, c5, CMD_CHECK,   1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'h7, 4'h0, 4'h0, 1'b0, c5, SIMD_SELECT, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'h7, 4'h0, 4'h0, 1'b0, c5, SIMD_LD1,    1'b0, 4'h8, 4'h0, KIND_LD1,  16'hA005, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h8, 4'h0, KIND_LD1,  16'hA005, cz);
        run(start);
        rstn = 1'b0;
        #1;
        check_outputs(-3, zv);
        @(negedge clk);
        rstn = 1'b1;
`ifdef ISSUER_PERF_CNT_EN
        check("issue_cnt_rst", -3, 64'(issue_cnt), 64'd0);
        check("wb_cnt_rst",    -3, 64'(wb_cnt),    64'd0);
`endif

        // Scoreboard emptied by reset: {6,5} issues instead of writing back
        start = vecs.size();
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'h7, 4'h0, 4'h0, 1'b0, c6, CMD_GET,     1'b1, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(3, 4'h7, 4'h0, 4'h0, 1'b0, c6, CMD_CHECK,   1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'h7, 4'h0, 4'h0, 1'b0, c6, SIMD_SELECT, 1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        add(1, 4'h7, 4'h0, 4'h0, 1'b0, c6, SIMD_LD1,    1'b0, 4'h8, 4'h0, KIND_LD1,  16'hA006, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h8, 4'h0, KIND_LD1,  16'hA006, cz);
        add(1, 4'hF, 4'h0, 4'h8, 1'b0, cz, SIMD_LD2,    1'b0, 4'h8, 4'h0, KIND_LD2,  16'hB006, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h8, 4'h0, KIND_LD2,  16'hB006, cz);
        add(1, 4'hF, 4'h0, 4'h8, 1'b0, cz, SIMD_INFO,   1'b0, 4'h8, 4'h0, KIND_INFO, 16'hC006, cz);
        add(1, 4'hF, 4'h0, 4'h0, 1'b0, cz, WAIT_ACK,    1'b0, 4'h8, 4'h0, KIND_INFO, 16'hC006, cz);
        add(1, 4'hF, 4'h0, 4'h8, 1'b0, cz, IDLE,        1'b0, 4'h0, 4'h0, KIND_NONE, 16'h0, cz);
        run(start);
`ifdef ISSUER_PERF_CNT_EN
        check("issue_cnt_end", -4, 64'(issue_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
